// File: rtl/fetch_sequencer.sv
// Fetch/execute phase controller in front of the instruction decoder; captures the RAM word and counts retirements.
// Optional single-step input when SINGLE_STEP_EN is defined.
module fetch_sequencer #(
  parameter int unsigned RAMI_LAT = 1,
  parameter logic [4:0]  STP_OP   = 5'b11111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        stall,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [15:0] RAMi_q,
  output logic        RAMi_en,
  output logic [15:0] instr,
  output logic        FETCH,
  output logic        EXEC,
  output logic        halted,
  output logic [15:0] retired
);

  localparam int CNT_W = $clog2(RAMI_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        instr_q, instr_d;
  logic [15:0]        retired_q;
  logic               capture;
  logic               retire;
  logic               step_go;
  logic               oneshot_q;

  assign capture = ((state_q == S_FETCH) && (RAMI_LAT == 1)) ||
                   ((state_q == S_WAIT) && (cnt_q == CNT_W'(1)));
  assign retire  = (state_q == S_EXEC) && !stall;

`ifdef SINGLE_STEP_EN
  // step is asynchronous to clk: two sync flops, third flop for edge detect
  logic [2:0] step_sync_q;
  logic       oneshot_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_sync_q <= 3'b000;
      oneshot_q   <= 1'b0;
    end else begin
      step_sync_q <= {step_sync_q[1:0], step};
      oneshot_q   <= oneshot_d;
    end
  end

  assign step_go = step_sync_q[1] & ~step_sync_q[2];

  always_comb begin
    oneshot_d = oneshot_q;
    if ((state_q == S_IDLE) && !run && step_go) begin
      oneshot_d = 1'b1;
    end else if (retire) begin
      oneshot_d = 1'b0;
    end
  end
`else
  assign step_go   = 1'b0;
  assign oneshot_q = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (run || step_go) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = (RAMI_LAT == 1) ? S_EXEC : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          if (instr_q[15:11] == STP_OP) begin
            state_d = S_HALT;
          end else if (run && !oneshot_q) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    RAMi_en = 1'b0;
    FETCH   = 1'b0;
    EXEC    = 1'b0;
    halted  = 1'b0;
    case (state_q)
      S_FETCH, S_WAIT: begin
        RAMi_en = 1'b1;
        FETCH   = 1'b1;
      end
      S_EXEC: begin
        EXEC = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        RAMi_en = 1'b0;
      end
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    instr_d = instr_q;
    if (state_q == S_FETCH) begin
      cnt_d = CNT_W'(RAMI_LAT - 1);
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (capture) begin
      instr_d = RAMi_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      instr_q   <= 16'h0000;
      retired_q <= 16'h0000;
    end else begin
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      if (retire) begin
        retired_q <= retired_q + 16'd1;
      end
    end
  end

  assign instr   = instr_q;
  assign retired = retired_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Phase controller that sits directly upstream of the instruction decoder in the 16-bit CPU. It sequences the IDLE/FETCH/WAIT/EXEC/HALT cycle and drives the instruction RAM enable. It captures the instruction word from instruction RAM and holds it stable during execute. It drives the decoder's `instr`, `FETCH` and `EXEC` inputs and counts retired instructions.

Parameters:
- RAMI_LAT, 1, number of cycles `RAMi_en` is held before `RAMi_q` is sampled. Legal range is 1..8; 0 is illegal.
- STP_OP, 5'b11111, value of instr[15:11] that encodes STP (halt).

Ports:
- clk  in  1  system clock; rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  level; permits fetching new instructions.
- stall  in  1  extends the current EXEC phase (for example, a data RAM access).
- RAMi_q  in  16  instruction RAM read data.
- RAMi_en  out  1  instruction RAM read enable.
- instr  out  16  captured instruction word, fed to the decoder.
- FETCH  out  1  fetch-phase flag, fed to the decoder.
- EXEC  out  1  execute-phase flag, fed to the decoder.
- halted  out  1  high once an STP instruction has retired.
- retired  out  16  count of retired instructions.
- step  in  1  single-step request; present only with SINGLE_STEP_EN.

Behaviour:
- One clock domain. Reset is asynchronous and active-low on rst_n.
- While rst_n=0:
  - state is IDLE;
  - instr=16'h0000 and retired=16'h0000;
  - FETCH, EXEC, RAMi_en and halted are all 0.
- All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- IDLE:
  - All flags are 0.
  - If run=1, move to FETCH on the next edge; otherwise stay.
- FETCH (exactly 1 cycle):
  - FETCH=1, RAMi_en=1.
  - If RAMI_LAT=1, capture instr<=RAMi_q at the closing edge and move to EXEC.
  - Otherwise load the wait counter with RAMI_LAT-1 and move to WAIT.
- WAIT:
  - FETCH=1, RAMi_en=1; the counter decrements each cycle.
  - At the edge where counter==1, capture instr<=RAMi_q and move to EXEC.
  - Counter width is $clog2(RAMI_LAT+1).
- Fetch latency: RAMi_en is high for exactly RAMI_LAT consecutive cycles, and EXEC asserts in the cycle after the last of them.
- EXEC:
  - EXEC=1, FETCH=0, RAMi_en=0; instr is held stable.
  - EXEC lasts a minimum of 1 cycle. While stall=1 at an edge, stay in EXEC.
  - At the first edge with stall=0, the instruction retires: retired increments (16'hFFFF wraps to 16'h0000).
  - Next state after retiring:
    - if instr[15:11]==STP_OP, go to HALT;
    - else if run=1, go to FETCH (back-to-back, no bubble);
    - else go to IDLE.
- HALT:
  - halted=1; all other flags are 0.
  - Terminal state; only rst_n leaves it. run and stall are ignored.
- Boundary rules:
  - stall is ignored outside EXEC.
  - run deasserting during FETCH/WAIT does not abort: the fetch and its EXEC complete, then the block goes to IDLE.
  - rst_n asserted mid-fetch or mid-exec immediately forces the reset values; the partially fetched word is discarded.
  - instr changes only at a capture edge.

Optional Feature:
SINGLE_STEP_EN
- Defined:
  - The `step` port exists and is synchronised through 2 flops, then rising-edge detected.
  - A detected edge while in IDLE with run=0 starts exactly one FETCH→EXEC sequence, after which the block returns to IDLE (or goes to HALT on STP).
  - Edges arriving in any other state are dropped.
- Undefined:
  - The `step` port and its synchroniser are absent.
  - IDLE is left only via run=1.

Test Plan:
1. Reset: hold rst_n=0 with run=1 → instr=0000, retired=0, all flags 0. Release → FETCH=1 on the first edge.
2. Fetch timing: RAMI_LAT=3, RAMi_q=16'h1234 → RAMi_en high for exactly 3 cycles, then EXEC=1 with instr=1234. With run=1 held, FETCH follows EXEC with no gap.
3. Stall: stall=1 for 3 cycles from EXEC entry → EXEC lasts 4 cycles; retired increments once, on the stall=0 edge.
4. Halt: RAMi_q=16'hF800 (STP) → after EXEC, halted=1 and RAMi_en stays 0 despite run=1. Pulse rst_n → IDLE.
5. Abort rules: run falls during WAIT → EXEC still occurs, then IDLE. rst_n low mid-WAIT → instr=0000 immediately and no EXEC.
6. Wrap / step: preload via 65536 retirements → retired wraps to 0000. With SINGLE_STEP_EN and run=0, one step pulse → exactly one EXEC cycle, then IDLE.
